// File: rtl/data_memory_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port data_memory.
// One access is in flight at a time; read data returns with a one-cycle rvalid pulse.
module data_memory_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned READ_LAT   = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_readData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arbState_t;

    // WAIT covers the READ_LAT-1 cycles after ACCESS; the counter ends at zero on the last one.
    localparam logic [15:0] WAIT_INIT = (READ_LAT > 32'd1) ? 16'(READ_LAT - 32'd2) : 16'd0;

    arbState_t   state_r;
    logic        lastGnt_r;
    logic        winner_r;
    logic [15:0] waitCnt_r;

    logic        pick_s;
    logic        pickWe_s;
    logic        capture_s;

    function automatic logic pickPort(input logic r0, input logic r1, input logic last);
        logic p;
        p = 1'b0;
        if (r0 && r1) begin
            if (FIXED_PRIO) begin
                p = 1'b0;
            end else begin
                p = ~last;
            end
        end else if (r1) begin
            p = 1'b1;
        end else begin
            p = 1'b0;
        end
        return p;
    endfunction

    // Winner selection and the end-of-read sampling condition.
    always_comb begin
        pick_s    = pickPort(req0, req1, lastGnt_r);
        pickWe_s  = pick_s ? we1 : we0;
        capture_s = 1'b0;
        if (state_r == ACCESS) begin
            capture_s = mem_MemRead && (READ_LAT <= 32'd1);
        end else if (state_r == WAIT) begin
            capture_s = (waitCnt_r == 16'd0);
        end else begin
            capture_s = 1'b0;
        end
    end

    // Sequencer FSM: latches the winner into the memory-side registers and paces the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            lastGnt_r     <= 1'b1;
            winner_r      <= 1'b0;
            waitCnt_r     <= 16'd0;
            mem_address   <= 32'h0000_0000;
            mem_writeData <= 32'h0000_0000;
            mem_MemRead   <= 1'b0;
            mem_MemWrite  <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        winner_r      <= pick_s;
                        lastGnt_r     <= pick_s;
                        mem_address   <= pick_s ? addr1 : addr0;
                        mem_writeData <= pick_s ? wdata1 : wdata0;
                        mem_MemWrite  <= pickWe_s;
                        mem_MemRead   <= ~pickWe_s;
                        gnt0          <= ~pick_s;
                        gnt1          <= pick_s;
                        waitCnt_r     <= WAIT_INIT;
                        state_r       <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (mem_MemWrite) begin
                        mem_MemWrite <= 1'b0;
                        state_r      <= IDLE;
                    end else if (capture_s) begin
                        mem_MemRead <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture_s) begin
                        mem_MemRead <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        waitCnt_r <= waitCnt_r - 16'd1;
                    end
                end
                default: begin
                    mem_MemRead  <= 1'b0;
                    mem_MemWrite <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Read-return path: load the winner's rdata and pulse its rvalid in the following IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0  <= 32'h0000_0000;
            rdata1  <= 32'h0000_0000;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (capture_s) begin
                if (winner_r) begin
                    rdata1  <= mem_readData;
                    rvalid1 <= 1'b1;
                end else begin
                    rdata0  <= mem_readData;
                    rvalid0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: two instances (round-robin/READ_LAT=1 and fixed/READ_LAT=3)
// driven with directed and random traffic, checked against a cycle-level reference model.
module tb_data_memory_arbiter;

    typedef struct packed {
        logic [31:0] e;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit [1:0] done = 2'b00;

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %h expected %h", g, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam bit          FP = (g == 1);
        localparam int unsigned RL = (g == 1) ? 3 : 1;

        logic        rstN;
        logic        req0, req1, we0, we1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic        gnt0, gnt1, rvalid0, rvalid1;
        logic [31:0] rdata0, rdata1, mAddr, mWd, mRd;
        logic        mRdEn, mWrEn;

        logic [31:0] dmem   [0:63] = '{default: 32'h0};
        logic [31:0] refMem [0:63] = '{default: 32'h0};
        exp_t q0[$];
        exp_t q1[$];

        int   ecnt     = 0;
        int   freeEdge = 0;
        bit   lastG    = 1'b1;
        int   gAt      = -1;
        bit   gPort    = 1'b0;
        int   wrAt     = -1;
        int   rdFrom   = 1;
        int   rdTo     = 0;
        bit   mp, mw;
        logic [31:0] expAddr = 32'h0;
        logic [31:0] expWd   = 32'h0;
        bit   eRd, eWr, eG;
        exp_t monEx;

        data_memory_arbiter #(.FIXED_PRIO(FP), .READ_LAT(RL)) dut (
            .clk(clk), .rst_n(rstN),
            .req0(req0), .req1(req1), .we0(we0), .we1(we1),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
            .rdata0(rdata0), .rdata1(rdata1),
            .mem_address(mAddr), .mem_writeData(mWd),
            .mem_MemRead(mRdEn), .mem_MemWrite(mWrEn), .mem_readData(mRd)
        );

        // data_memory stand-in: synchronous write, combinational read
        always @(posedge clk) if (mWrEn) dmem[mAddr[7:2]] <= mWd;
        assign mRd = dmem[mAddr[7:2]];

        // Reference model: which edge samples a request, who wins, and when strobes are expected.
        always @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                lastG = 1'b1; freeEdge = 0; gAt = -1; wrAt = -1; rdFrom = 1; rdTo = 0;
                q0.delete(); q1.delete();
            end else begin
                ecnt = ecnt + 1;
                if (ecnt >= freeEdge && (req0 || req1)) begin
                    mp = (req0 && req1) ? (FP ? 1'b0 : !lastG) : req1;
                    lastG = mp;
                    mw = mp ? we1 : we0;
                    expAddr = mp ? addr1 : addr0;
                    expWd = mp ? wdata1 : wdata0;
                    gAt = ecnt; gPort = mp;
                    if (mw) begin
                        wrAt = ecnt; freeEdge = ecnt + 2;
                    end else begin
                        rdFrom = ecnt; rdTo = ecnt + int'(RL) - 1; freeEdge = ecnt + int'(RL) + 1;
                    end
                end
            end
        end

        // Monitor: per-cycle strobe/grant checks and scoreboard pops on rvalid.
        always @(negedge clk) begin
            eRd = rstN && (ecnt >= rdFrom) && (ecnt <= rdTo);
            eWr = rstN && (ecnt == wrAt);
            eG  = rstN && (ecnt == gAt);
            chk(g, "gnt", {62'd0, gnt1, gnt0}, {62'd0, eG && gPort, eG && !gPort});
            chk(g, "strobes", {62'd0, mRdEn, mWrEn}, {62'd0, eRd, eWr});
            if (eRd || eWr) chk(g, "mem_address", {32'd0, mAddr}, {32'd0, expAddr});
            if (eWr) chk(g, "mem_writeData", {32'd0, mWd}, {32'd0, expWd});
            if (rvalid0) begin
                if (q0.size() == 0) chk(g, "rvalid0_unexpected", 64'd1, 64'd0);
                else begin
                    monEx = q0.pop_front();
                    chk(g, "rdata0_edge", {ecnt, rdata0}, {monEx.e, monEx.d});
                end
            end else if (q0.size() != 0 && int'(q0[0].e) < ecnt) begin
                monEx = q0.pop_front();
                chk(g, "rvalid0_missing", 64'd0, 64'd1);
            end
            if (rvalid1) begin
                if (q1.size() == 0) chk(g, "rvalid1_unexpected", 64'd1, 64'd0);
                else begin
                    monEx = q1.pop_front();
                    chk(g, "rdata1_edge", {ecnt, rdata1}, {monEx.e, monEx.d});
                end
            end else if (q1.size() != 0 && int'(q1[0].e) < ecnt) begin
                monEx = q1.pop_front();
                chk(g, "rvalid1_missing", 64'd0, 64'd1);
            end
        end

        task automatic issue(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
            bit got = 1'b0;
            if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
            else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                got = p ? gnt1 : gnt0;
            end
            if (!got) chk(g, p ? "gnt1_timeout" : "gnt0_timeout", 64'd0, 64'd1);
            else if (w) refMem[a[7:2]] = d;
            else if (p) q1.push_back(exp_t'{e: 32'(ecnt + int'(RL)), d: refMem[a[7:2]]});
            else q0.push_back(exp_t'{e: 32'(ecnt + int'(RL)), d: refMem[a[7:2]]});
            if (p) req1 = 1'b0; else req0 = 1'b0;
        endtask

        task automatic chkZero(input string nm);
            chk(g, {nm, "_ctl"}, {58'd0, gnt0, gnt1, rvalid0, rvalid1, mRdEn, mWrEn}, 64'd0);
            chk(g, {nm, "_mem"}, {mAddr, mWd}, 64'd0);
            chk(g, {nm, "_rdata"}, {rdata0, rdata1}, 64'd0);
        endtask

        initial begin : ctrl
            req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
            addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
            rstN = 1'b1;
            #1 rstN = 1'b0;
            repeat (3) @(negedge clk);
            chkZero("reset_state");
            #2 rstN = 1'b1;
            @(negedge clk);
            issue(1'b0, 1'b1, 32'h0000_0000, 32'd10);
            issue(1'b0, 1'b0, 32'h0000_0000, 32'h0);
            issue(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
            issue(1'b1, 1'b0, 32'h0000_0008, 32'h0);
            issue(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0055);
            issue(1'b0, 1'b0, 32'h0000_0004, 32'h0);
            repeat (8) @(negedge clk);
            fork
                begin
                    for (int k = 0; k < 25; k++) begin
                        repeat ($urandom_range(0, 6)) @(negedge clk);
                        issue(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 32'd4, $urandom);
                    end
                end
                begin
                    for (int k = 0; k < 25; k++) begin
                        repeat ($urandom_range(0, 6)) @(negedge clk);
                        issue(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 32'd4, $urandom);
                    end
                end
            join
            // back-to-back reads on both ports
            fork
                for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 32'h0000_0000, 32'h0);
                for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, 32'h0000_0008, 32'h0);
            join
            repeat (10) @(negedge clk);
            // reset in the middle of a read
            issue(1'b0, 1'b0, 32'h0000_0004, 32'h0);
            repeat (RL - 1) @(negedge clk);
            #2 rstN = 1'b0;
            #1 chkZero("reset_midread");
            @(negedge clk);
            #2 rstN = 1'b1;
            fork
                issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
                issue(1'b1, 1'b0, 32'h0000_0014, 32'h0);
            join
            repeat (10) @(negedge clk);
            chk(g, "scoreboard_drained", {32'(q0.size()), 32'(q1.size())}, 64'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done != 2'b11; i++) @(negedge clk);
        if (done != 2'b11) begin
            total++;
            bad++;
            $display("FAIL overall_timeout: got done=%b expected 11", done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
